// File: rtl/channel_router_pkg.sv
// Shared constants for channel_router: lane FSM state encoding, source codes
// and the switch-timeout counter width.
package channel_router_pkg;

  // Lane FSM state encoding
  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_SWITCH = 2'd3;

  // Source codes carried on the selector inputs
  localparam logic SRC_PPS   = 1'b0;
  localparam logic SRC_PULSE = 1'b1;

  // Width of the per-lane SWITCH dwell counter
  localparam int unsigned TO_W = 16;

endpackage

// File: rtl/channel_router_lane.sv
// One glitch-free routing lane: picks pps_divided or pulse_generated for one
// channel, only starting or changing source while the relevant sources are low.
// Optional forced switch after TimeoutCyc cycles in SWITCH when the macro
// CHANNEL_ROUTER_SWITCH_TIMEOUT_EN is defined.
module channel_router_lane
  import channel_router_pkg::*;
#(
  parameter int unsigned TimeoutCyc = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pps_i,
  input  logic pulse_i,
  input  logic enable_i,
  input  logic sel_i,
  output logic chan_o,
  output logic pending_o,
  output logic switched_o
);

  if (TimeoutCyc < 2 || TimeoutCyc > 65535) begin : g_param_check
    $error("channel_router_lane: TimeoutCyc out of range 2..65535");
  end

  logic [1:0] state_q, state_d;
  logic       act_sel_q, act_sel_d;
  logic       chan_q, chan_d;
  logic       sw_q, sw_d;
  logic       cur_src;
  logic       alt_src;
  logic       force_sw;

  // Currently routed source and the other one (the target of any pending switch)
  assign cur_src = (act_sel_q == SRC_PULSE) ? pulse_i : pps_i;
  assign alt_src = (act_sel_q == SRC_PULSE) ? pps_i : pulse_i;

`ifdef CHANNEL_ROUTER_SWITCH_TIMEOUT_EN
  localparam logic [TO_W-1:0] CntLast = TO_W'(TimeoutCyc - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Count cycles spent in SWITCH; any other state rearms the counter at zero
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_SWITCH) cnt_d = cnt_q + TO_W'(1);
  end

  assign force_sw = (state_q == ST_SWITCH) && (cnt_q == CntLast);

  // Dwell counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign force_sw = 1'b0;
`endif

  // Lane FSM next state; disable always wins over a selector change
  always_comb begin
    state_d   = state_q;
    act_sel_d = act_sel_q;
    chan_d    = 1'b0;
    sw_d      = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (enable_i) begin
          act_sel_d = sel_i;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        // Wait for a low level so the first emitted pulse is complete
        if (!enable_i)     state_d = ST_OFF;
        else if (!cur_src) state_d = ST_RUN;
      end
      ST_RUN: begin
        chan_d = cur_src;
        if (!enable_i) begin
          if (!cur_src) state_d = ST_OFF;
        end else if (sel_i != act_sel_q) begin
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        chan_d = cur_src;
        if (!enable_i) begin
          // Drop the request; RUN drains a high pulse before going OFF
          state_d = cur_src ? ST_RUN : ST_OFF;
        end else if (sel_i == act_sel_q) begin
          state_d = ST_RUN;
        end else if ((!cur_src && !alt_src) || force_sw) begin
          act_sel_d = sel_i;
          state_d   = ST_RUN;
          sw_d      = 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Lane state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_OFF;
      act_sel_q <= SRC_PPS;
      chan_q    <= 1'b0;
      sw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_sel_q <= act_sel_d;
      chan_q    <= chan_d;
      sw_q      <= sw_d;
    end
  end

  assign chan_o     = chan_q;
  assign pending_o  = (state_q == ST_SWITCH);
  assign switched_o = sw_q;

endmodule

// File: rtl/channel_router.sv
// Top of the channel router: N_CH independent lanes, each routing one of two
// pulse sources to its output without runt pulses. Build with
// CHANNEL_ROUTER_SWITCH_TIMEOUT_EN to enable the forced-switch timeout.
module channel_router #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_pps_divided,
  input  logic [N_CH-1:0] i_pulse_generated,
  input  logic [N_CH-1:0] i_enable,
  input  logic [N_CH-1:0] i_selector,
  output logic [N_CH-1:0] o_channel,
  output logic [N_CH-1:0] o_pending,
  output logic [N_CH-1:0] o_switched
);

  if (N_CH < 1 || N_CH > 16) begin : g_param_check
    $error("channel_router: N_CH out of range 1..16");
  end

  // One self-contained lane per channel
  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    channel_router_lane #(
      .TimeoutCyc(TIMEOUT_CYC)
    ) u_lane (
      .clk_i     (i_clk),
      .rst_ni    (i_rst_n),
      .pps_i     (i_pps_divided[g]),
      .pulse_i   (i_pulse_generated[g]),
      .enable_i  (i_enable[g]),
      .sel_i     (i_selector[g]),
      .chan_o    (o_channel[g]),
      .pending_o (o_pending[g]),
      .switched_o(o_switched[g])
    );
  end

endmodule

// File: doc/channel_router.md
CHANNEL_ROUTER -- requirements
Module: channel_router

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of independent output channels (1..16).
REQ-002 Parameter TIMEOUT_CYC, default 1024, SHALL set the forced-switch limit in clock cycles (2..65535; used only when the Configuration macro is defined).
REQ-003 i_clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_pps_divided  input  N_CH  SHALL be source 0 per channel, synchronous to i_clk.
REQ-006 i_pulse_generated  input  N_CH  SHALL be source 1 per channel, synchronous to i_clk.
REQ-007 i_enable  input  N_CH  SHALL be the per-channel enable, level-sensitive.
REQ-008 i_selector  input  N_CH  SHALL be the per-channel requested source (0=pps_divided, 1=pulse_generated).
REQ-009 o_channel  output  N_CH  SHALL be the registered routed channel output.
REQ-010 o_pending  output  N_CH  SHALL be high while a channel has an accepted but unapplied source change.
REQ-011 o_switched  output  N_CH  SHALL pulse high for one cycle in the cycle after a source change is applied.

Function
REQ-012 Each channel SHALL run an independent FSM with states OFF, ARM, RUN and SWITCH, plus an active-source register act_sel.
REQ-013 In OFF, the channel SHALL drive o_channel=0, and i_enable=1 SHALL load act_sel<=i_selector and move the channel to ARM.
REQ-014 ARM SHALL hold o_channel=0 until the source selected by act_sel is sampled low, then move to RUN, so that no partial (runt) pulse is emitted.
REQ-015 In RUN, o_channel SHALL equal the act_sel source delayed by exactly one clock.
REQ-016 In RUN with i_selector!=act_sel, the channel SHALL move to SWITCH, and o_pending SHALL be 1 from the next cycle.
REQ-017 SWITCH SHALL keep following the old source, and SHALL apply act_sel<=i_selector and return to RUN in the first cycle in which both the old and the new source are sampled low.
REQ-018 If i_selector returns to act_sel while in SWITCH, the channel SHALL return to RUN with no o_switched pulse.
REQ-019 i_enable=0 in RUN or SWITCH SHALL move the channel to OFF at the first cycle the current source is low, letting any high pulse complete, and SHALL clear o_pending.
REQ-020 i_enable=0 in ARM SHALL move the channel to OFF immediately.
REQ-021 When disable and a selector change occur in the same cycle, disable SHALL take priority.
REQ-022 Channels SHALL NOT interact; a simultaneous change on all N_CH channels SHALL be handled independently per channel.

Reset
REQ-023 While i_rst_n=0, every channel SHALL be in OFF with o_channel=0, o_pending=0, o_switched=0, act_sel=0 and the timeout counter at 0.
REQ-024 Reset assertion mid-pulse or mid-switch SHALL force the outputs low asynchronously, and the first post-reset cycle SHALL evaluate from OFF.

Configuration
REQ-025 With CHANNEL_ROUTER_SWITCH_TIMEOUT_EN defined, a 16-bit per-channel counter SHALL count cycles spent in SWITCH, and on reaching TIMEOUT_CYC SHALL force the switch (act_sel<=i_selector, return to RUN, pulse o_switched) regardless of source levels.
REQ-026 Without CHANNEL_ROUTER_SWITCH_TIMEOUT_EN, no counter SHALL exist and SWITCH SHALL wait indefinitely for the both-low condition.

Structure
REQ-027 A package channel_router_pkg SHALL hold the FSM state enum (OFF, ARM, RUN, SWITCH), the source codes SRC_PPS=0 and SRC_PULSE=1, and the counter width constant TO_W=16.
REQ-028 Per-channel logic SHALL live in sub-module channel_router_lane, instantiated N_CH times by a generate loop in channel_router.

Verification
REQ-029 Reset release, then i_enable[0]=1 with sel=0 while pps_divided[0] is high for 3 cycles -> o_channel[0] stays 0 until pps goes low, then follows pps with 1-cycle latency.
REQ-030 RUN on sel=0, flip sel to 1 while pps is high and pulse is high -> o_pending=1, old source followed; first both-low cycle -> o_switched 1-cycle pulse, then pulse_generated routed.
REQ-031 In SWITCH, return sel to 0 after 5 cycles -> back to RUN, o_pending=0, o_switched never asserted.
REQ-032 Deassert i_enable mid-pulse (source high for 4 more cycles) -> full pulse emitted, then o_channel=0 and state OFF; disable plus sel change in the same cycle -> no o_switched.
REQ-033 With the macro and TIMEOUT_CYC=8, hold pulse_generated high and request a switch from source 1 to 0 -> forced switch after 8 SWITCH cycles with o_switched pulse; without the macro -> o_pending stays 1 indefinitely.
REQ-034 N_CH=4 with all channels switching in the same cycle on differing source waveforms, plus i_rst_n asserted mid-switch -> each channel applies its switch independently, and all outputs go 0 immediately on reset.
